// File: rtl/sd_cmd_engine.sv
// sd_cmd_engine: SD CMD-line engine - serialises a 48-bit command, receives R48/R136 responses,
// checks CRC7 and end bit, enforces NCR timeout and NCC gap, and retries failed attempts.
module sd_cmd_engine #(
    parameter int RESP_TIMEOUT = 64,
    parameter int MAX_RETRIES  = 2,
    parameter int NCC_CYCLES   = 8
) (
    input  logic         iclk,
    input  logic         irst_n,
    input  logic         icmd_sd,
    output logic         ocmd_sd,
    output logic         ocmd_oe,
    input  logic         istart_valid,
    output logic         ostart_ready,
    input  logic [5:0]   icmd_index,
    input  logic [31:0]  icmd_arg,
    input  logic [1:0]   iresp_type,
    output logic [119:0] oresp,
    output logic         odone,
    output logic         oerr_timeout,
    output logic         oerr_crc,
    output logic         oerr_end,
    output logic [1:0]   oattempts
);
    typedef enum logic [2:0] {S_IDLE, S_TX, S_WAIT, S_RX, S_CRC, S_END, S_GAP} state_t;

    localparam logic [15:0] TO_LAST  = 16'(RESP_TIMEOUT - 1);
    localparam logic [15:0] GAP_LAST = 16'(NCC_CYCLES - 1);

    state_t         r_state, w_next;
    logic [15:0]    r_cnt;
    logic [5:0]     r_idx;
    logic [31:0]    r_arg;
    logic [1:0]     r_type, r_att;
    logic [6:0]     r_crc;
    logic [119:0]   r_resp;
    logic           r_done, r_err_to, r_err_crc, r_err_end;
    logic           r_f_to, r_f_crc, r_f_end;
    logic [39:0]    w_frame;
    logic           w_txbit, w_final, w_hdr;
    logic [15:0]    w_rx_last;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        return {c[5:0], 1'b0} ^ ((b ^ c[6]) ? 7'h09 : 7'h00);
    endfunction

    assign w_frame      = {2'b01, r_idx, r_arg};
    assign w_txbit      = (r_cnt < 16'd40) ? w_frame[6'd39 - r_cnt[5:0]] :
                          (r_cnt < 16'd47) ? r_crc[6] : 1'b1;
    assign w_final      = !(r_f_to || r_f_crc || r_f_end) || (r_att == 2'(MAX_RETRIES));
    // R136 carries 7 header bits that are neither stored nor covered by the CRC
    assign w_hdr        = (r_type == 2'b11) && (r_cnt < 16'd7);
    assign w_rx_last    = (r_type == 2'b11) ? 16'd126 : 16'd38;
    assign ocmd_oe      = (r_state == S_TX);
    assign ocmd_sd      = ocmd_oe ? w_txbit : 1'b1;
    assign ostart_ready = (r_state == S_IDLE);
    assign oresp        = r_resp;
    assign odone        = r_done;
    assign oerr_timeout = r_err_to;
    assign oerr_crc     = r_err_crc;
    assign oerr_end     = r_err_end;
    assign oattempts    = r_att;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (istart_valid) w_next = S_TX;
            S_TX:    if (r_cnt == 16'd47) w_next = (r_type == 2'b00) ? S_GAP : S_WAIT;
            S_WAIT:  if (!icmd_sd) w_next = S_RX; else if (r_cnt == TO_LAST) w_next = S_GAP;
            S_RX:    if (r_cnt == w_rx_last) w_next = S_CRC;
            S_CRC:   if (r_cnt == 16'd6) w_next = S_END;
            S_END:   w_next = S_GAP;
            S_GAP:   if (r_cnt == GAP_LAST) w_next = w_final ? S_IDLE : S_TX;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? '0 : r_cnt + 16'd1;
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_idx     <= '0;
            r_arg     <= '0;
            r_type    <= '0;
            r_att     <= '0;
            r_crc     <= '0;
            r_resp    <= '0;
            r_done    <= 1'b0;
            r_err_to  <= 1'b0;
            r_err_crc <= 1'b0;
            r_err_end <= 1'b0;
            r_f_to    <= 1'b0;
            r_f_crc   <= 1'b0;
            r_f_end   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (istart_valid) begin
                    r_idx     <= icmd_index;
                    r_arg     <= icmd_arg;
                    r_type    <= iresp_type;
                    r_att     <= '0;
                    r_crc     <= '0;
                    r_err_to  <= 1'b0;
                    r_err_crc <= 1'b0;
                    r_err_end <= 1'b0;
                    r_f_to    <= 1'b0;
                    r_f_crc   <= 1'b0;
                    r_f_end   <= 1'b0;
                end
                S_TX:   r_crc <= (r_cnt < 16'd40) ? crc7_step(r_crc, w_txbit) : {r_crc[5:0], 1'b0};
                S_WAIT: if (!icmd_sd) begin
                    r_crc  <= '0;
                    r_resp <= '0;
                end else if (r_cnt == TO_LAST) r_f_to <= 1'b1;
                S_RX:   if (!w_hdr) begin
                    r_crc  <= crc7_step(r_crc, icmd_sd);
                    r_resp <= {r_resp[118:0], icmd_sd};
                end
                S_CRC: begin
                    if (icmd_sd != r_crc[6] && r_type != 2'b10) r_f_crc <= 1'b1;
                    r_crc <= {r_crc[5:0], 1'b0};
                end
                S_END:  if (!icmd_sd) r_f_end <= 1'b1;
                S_GAP:  if (r_cnt == GAP_LAST) begin
                    // flags of a retried attempt are dropped; only the final attempt reports
                    r_crc   <= '0;
                    r_f_to  <= 1'b0;
                    r_f_crc <= 1'b0;
                    r_f_end <= 1'b0;
                    if (w_final) begin
                        r_done    <= 1'b1;
                        r_err_to  <= r_f_to;
                        r_err_crc <= r_f_crc;
                        r_err_end <= r_f_end;
                    end else r_att <= r_att + 2'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_cmd_engine.sv
// tb_sd_cmd_engine: directed bench; a per-transaction cycle timeline built from the protocol rules
// is compared against the DUT on every cycle, with literal frames/CRCs pinning the model.
module tb_sd_cmd_engine;
    localparam int TO   = 64;
    localparam int MAXR = 2;
    localparam int NCC  = 8;

    logic         iclk = 1'b0, irst_n = 1'b0, icmd_sd = 1'b1, istart_valid = 1'b0;
    logic [5:0]   icmd_index = '0;
    logic [31:0]  icmd_arg = '0;
    logic [1:0]   iresp_type = '0;
    logic         ocmd_sd, ocmd_oe, ostart_ready, odone, oerr_timeout, oerr_crc, oerr_end;
    logic [119:0] oresp;
    logic [1:0]   oattempts;

    always #5 iclk = ~iclk;

    sd_cmd_engine #(.RESP_TIMEOUT(TO), .MAX_RETRIES(MAXR), .NCC_CYCLES(NCC)) dut (
        .iclk(iclk), .irst_n(irst_n), .icmd_sd(icmd_sd), .ocmd_sd(ocmd_sd), .ocmd_oe(ocmd_oe),
        .istart_valid(istart_valid), .ostart_ready(ostart_ready), .icmd_index(icmd_index),
        .icmd_arg(icmd_arg), .iresp_type(iresp_type), .oresp(oresp), .odone(odone),
        .oerr_timeout(oerr_timeout), .oerr_crc(oerr_crc), .oerr_end(oerr_end), .oattempts(oattempts)
    );

    int checks = 0, failures = 0;

    logic         exp_oe [0:1023];
    logic         exp_sd [0:1023];
    logic         drv    [0:1023];
    logic [135:0] a_bits [0:2];
    int           a_len  [0:2];
    int           a_d    [0:2];
    int           done_at;
    logic         e_to, e_crc, e_end;
    logic [1:0]   e_att;
    logic [119:0] e_resp = '0;
    logic [47:0]  tx_cap;

    task automatic chk(input string name, input logic [119:0] act, input logic [119:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] crc7(input logic [135:0] v, input int n);
        logic [6:0] c = '0;
        for (int i = n - 1; i >= 0; i--) c = {c[5:0], 1'b0} ^ ((v[i] ^ c[6]) ? 7'h09 : 7'h00);
        return c;
    endfunction

    function automatic logic [47:0] cmd_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] b = {2'b01, idx, arg};
        return {b, crc7({96'b0, b}, 40), 1'b1};
    endfunction

    function automatic logic [135:0] r48(input logic [39:0] body, input logic [6:0] cx, input logic e);
        return {88'b0, body, crc7({96'b0, body}, 40) ^ cx, e};
    endfunction

    function automatic logic [135:0] r136(input logic [119:0] cid);
        return {2'b00, 6'h3F, cid, crc7({16'b0, cid}, 120), 1'b1};
    endfunction

    // Expected per-cycle timeline, counted from the cycle after the accepting edge.
    task automatic build(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] typ);
        logic [47:0] cf;
        int pos, g;
        logic fto, fcrc, fend;
        cf = cmd_frame(idx, arg);
        pos = 0;
        done_at = -1;
        for (int i = 0; i < 1024; i++) begin
            exp_oe[i] = 1'b0;
            exp_sd[i] = 1'b1;
            drv[i] = 1'b1;
        end
        for (int a = 0; a <= MAXR && done_at < 0; a++) begin
            for (int c = 0; c < 48; c++) begin
                exp_oe[pos + c] = 1'b1;
                exp_sd[pos + c] = cf[47 - c];
            end
            pos += 48;
            fto = 1'b0; fcrc = 1'b0; fend = 1'b0;
            if (typ == 2'b00) g = pos;
            else if (a_d[a] < 0) begin
                fto = 1'b1;
                g = pos + TO;
            end else begin
                for (int k = 0; k < a_len[a]; k++) drv[pos + a_d[a] + k] = a_bits[a][a_len[a] - 1 - k];
                g = pos + a_d[a] + a_len[a];
                fend = !a_bits[a][0];
                if (a_len[a] == 48) begin
                    e_resp = {80'b0, a_bits[a][47:8]};
                    fcrc = (typ == 2'b01) && (crc7(a_bits[a] >> 8, 40) != a_bits[a][7:1]);
                end else begin
                    e_resp = a_bits[a][127:8];
                    fcrc = (typ == 2'b11) && (crc7(a_bits[a] >> 8, 120) != a_bits[a][7:1]);
                end
            end
            pos = g + NCC;
            if (!(fto || fcrc || fend) || a == MAXR) begin
                done_at = pos;
                e_to = fto; e_crc = fcrc; e_end = fend;
                e_att = 2'(a);
            end
        end
    endtask

    task automatic run(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] typ, input logic hold);
        build(idx, arg, typ);
        tx_cap = '0;
        @(negedge iclk);
        istart_valid = 1'b1; icmd_index = idx; icmd_arg = arg; iresp_type = typ;
        for (int c = 0; c <= done_at + 1; c++) begin
            @(negedge iclk);
            if (c == 0) begin
                icmd_index = ~idx; icmd_arg = ~arg; iresp_type = ~typ;
                istart_valid = hold;
            end
            if (c == done_at - 1) istart_valid = 1'b0;
            icmd_sd = drv[c];
            if (ocmd_oe) tx_cap = {tx_cap[46:0], ocmd_sd};
            chk($sformatf("oe@%0d", c), ocmd_oe, exp_oe[c]);
            chk($sformatf("sd@%0d", c), ocmd_sd, exp_sd[c]);
            chk($sformatf("ready@%0d", c), ostart_ready, c >= done_at);
            chk($sformatf("done@%0d", c), odone, c == done_at);
            if (c == done_at) begin
                chk("err_timeout", oerr_timeout, e_to);
                chk("err_crc", oerr_crc, e_crc);
                chk("err_end", oerr_end, e_end);
                chk("attempts", oattempts, e_att);
                chk("resp", oresp, e_resp);
            end
        end
        icmd_sd = 1'b1;
    endtask

    initial begin
        chk("crc_cmd0", crc7({96'b0, 40'h4000000000}, 40), 7'h4A);
        chk("crc_cmd17", crc7({96'b0, 40'h5100000000}, 40), 7'h2A);
        chk("crc_r1", crc7({96'b0, 40'h1100000900}, 40), 7'h33);
        #1;
        chk("rst_oe", ocmd_oe, 1'b0);
        chk("rst_sd", ocmd_sd, 1'b1);
        chk("rst_done", odone, 1'b0);
        chk("rst_err", {oerr_timeout, oerr_crc, oerr_end}, 3'b000);
        chk("rst_resp", oresp, 120'b0);
        repeat (2) @(negedge iclk);
        irst_n = 1'b1;
        @(negedge iclk);
        chk("rst_ready", ostart_ready, 1'b1);

        run(6'd0, 32'h0, 2'b00, 1'b0);
        chk("cmd0_frame", tx_cap, 48'h400000000095);

        a_bits[0] = {88'b0, 40'h1100000900, 7'h33, 1'b1}; a_len[0] = 48; a_d[0] = 2;
        run(6'd17, 32'h0, 2'b01, 1'b0);
        chk("cmd17_frame", tx_cap, 48'h510000000055);
        chk("r1_literal", oresp, 120'h1100000900);

        for (int a = 0; a < 3; a++) a_d[a] = -1;
        run(6'd17, 32'h1234, 2'b01, 1'b1);

        a_bits[0] = r48(40'h1100000900, 7'h01, 1'b1); a_len[0] = 48; a_d[0] = 0;
        a_bits[1] = r48(40'h1100000A00, 7'h00, 1'b1); a_len[1] = 48; a_d[1] = TO - 1;
        run(6'd17, 32'h200, 2'b01, 1'b0);
        chk("retry_resp", oresp, 120'h1100000A00);

        a_bits[0] = r136({15{8'hA5}}); a_len[0] = 136; a_d[0] = 3;
        run(6'd2, 32'h0, 2'b11, 1'b0);
        chk("cid_literal", oresp, {15{8'hA5}});

        a_bits[0] = r48(40'h3F80FF8000, 7'h55, 1'b1); a_len[0] = 48; a_d[0] = 1;
        run(6'd41, 32'h40FF8000, 2'b10, 1'b0);

        for (int a = 0; a < 3; a++) begin
            a_bits[a] = r48(40'h0D00000900, 7'h10, 1'b0); a_len[a] = 48; a_d[a] = 4;
        end
        run(6'd13, 32'h10000, 2'b01, 1'b0);

        @(negedge iclk);
        istart_valid = 1'b1; icmd_index = 6'd17; icmd_arg = 32'h0; iresp_type = 2'b01;
        @(negedge iclk);
        istart_valid = 1'b0;
        repeat (10) @(negedge iclk);
        chk("midtx_oe", ocmd_oe, 1'b1);
        #2 irst_n = 1'b0;
        #1;
        chk("async_oe", ocmd_oe, 1'b0);
        chk("async_sd", ocmd_sd, 1'b1);
        chk("async_resp", oresp, 120'b0);
        @(negedge iclk);
        irst_n = 1'b1;
        e_resp = '0;
        for (int c = 0; c < 130; c++) begin
            @(negedge iclk);
            chk($sformatf("post_rst_idle@%0d", c), {odone, ocmd_oe, ostart_ready}, 3'b001);
        end

        a_bits[0] = {88'b0, 40'h1100000900, 7'h33, 1'b1}; a_len[0] = 48; a_d[0] = 2;
        run(6'd17, 32'h0, 2'b01, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
